stream_frame_sequencer: RTL
===========================

# stream_frame_sequencer

Sits between the pad-side 8-bit input stream and the DSP chain's `in_0` AXI-stream port, and decides when pad samples are admitted. It gates the pad stream on and off, groups samples into frames of a programmed length, and generates `last` on the final sample of each frame. It runs a programmed number of frames, or runs continuously until a graceful stop. A 2-entry skid buffer registers the ready path back to the pads.

## Interface
- `DATA_W`, 8, sample width.
- `LEN_W`, 12, frame-length counter width.
- `FRM_W`, 8, frame-count width.

Ports (clock and reset first):
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `cfg_start` in 1: one-cycle pulse; starts a run when IDLE.
- `cfg_stop` in 1: one-cycle pulse; finishes the current frame, then stops.
- `cfg_len_m1` in LEN_W: samples per frame minus 1; latched on start.
- `cfg_num_frames` in FRM_W: frames per run, 0 = continuous; latched on start.
- `s_valid` in 1: pad sample valid.
- `s_data` in DATA_W: pad sample.
- `s_ready` out 1: registered; drives the pad ready pin.
- `m_valid` out 1: to `in_0_valid`.
- `m_data` out DATA_W: to `in_0_bits_data`.
- `m_last` out 1: to `in_0_bits_last`.
- `m_ready` in 1: from `in_0_ready`.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `frames_out` out FRM_W: frames fully delivered (output `m_last` handshakes) in the current/last run.

## Operation
- **States:**
  - IDLE: `s_ready`=0.
  - RUN: accept samples.
  - DRAIN: `s_ready`=0; wait for the buffer to empty.
- **IDLE→RUN** on `cfg_start`:
  - latch `cfg_len_m1` and `cfg_num_frames`;
  - clear `in_cnt`, `frames_in`, `frames_out` and `stop_pend`.
- **Ignored inputs:**
  - `cfg_start` outside IDLE is ignored.
  - `cfg_stop` in IDLE is ignored.
  - Start and stop in the same IDLE cycle: start wins, stop is dropped.
- **Accept** = `s_valid` & `s_ready`.
  - Each accepted sample is pushed as {last, data}.
  - last = (`in_cnt` == len_m1).
  - `in_cnt` wraps to 0 after the last sample; otherwise it increments.
- **Frame completion on the input side** (last-tagged accept):
  - `frames_in` increments.
  - Go to DRAIN if `stop_pend`, or if num_frames != 0 and `frames_in`+1 == num_frames.
- **`cfg_stop` in RUN** sets `stop_pend`.
  - A stop arriving in the same cycle as a last-tagged accept ends the run at that frame.
  - Mid-frame, accepts continue until the frame's last sample.
- **DRAIN→IDLE** when the buffer is empty and no output handshake is pending; `done`=1 for that one cycle.
- `frames_out` increments on every `m_valid` & `m_ready` & `m_last`, saturating at max.
- **Width rules:**
  - len_m1 = 0 gives 1-sample frames (every sample has `last`).
  - len_m1 = all-ones gives 2^LEN_W samples.
  - In continuous mode `frames_in` wraps and never triggers DRAIN.
- **Reset:**
  - State=IDLE, buffer emptied, all counters cleared.
  - `s_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `done`=0.
  - Reset mid-run discards buffered samples without emitting `last`.

## Timing
- `s_ready` is a flop output:
  - next = (next_state == RUN) & (next_fill < 2).
  - It goes to 0 in the cycle after the final accepted sample of a run; no extra sample is accepted.
- Latency: a sample accepted in cycle t, with the buffer empty, appears on `m_data` in cycle t+1.
- Throughput: 1 sample/cycle while `m_ready`=1.
- **Backpressure:** with `m_ready`=0, at most 2 samples are buffered. `s_ready` falls the cycle after the fill reaches 2, and rises the cycle after it drops below 2.
- **AXI-stream rules:**
  - `m_valid` is never withdrawn before its handshake.
  - `m_data` and `m_last` are stable while `m_valid`=1 & `m_ready`=0.
- First accept is possible in the cycle after `cfg_start`.

## Structure
- Package `hs_stream_pkg`:
  - state enum {IDLE, RUN, DRAIN};
  - default widths `DATA_W`, `LEN_W`, `FRM_W`.
- Sub-module `axis_skid_buffer`:
  - 2 entries, payload width DATA_W+1;
  - ports: push/pop handshakes, fill count, flush on reset.
- Top holds the FSM, the counters and `s_ready` generation.

## Test plan
- **Single run:** len_m1=3, num_frames=2, `s_valid`/`m_ready` held 1 → exactly 8 samples pass, `m_last` on samples 4 and 8, `s_ready`=0 after the 8th accept, `done` pulse, `frames_out`=2.
- **Backpressure:** as above with `m_ready` toggling 1/0 every cycle → data order intact, fill never exceeds 2, no sample dropped or duplicated, data stable while stalled.
- **Graceful stop:** continuous mode, len_m1=9, `cfg_stop` at the 14th accept → accepts stop after sample 20, `m_last` on samples 10 and 20, `frames_out`=2, `done` pulses once.
- **Stop coinciding with last:** `cfg_stop` in the same cycle as the 10th accept (len_m1=9) → run ends at 10 samples with no 11th accept.
- **Edge lengths:** len_m1=0, num_frames=3 → 3 samples, all with `m_last`=1; separately, `cfg_start`+`cfg_stop` together in IDLE → run starts and is not stopped.
- **Reset mid-run:** `wb_rst_i` with 2 samples buffered → next cycle `m_valid`=0, `s_ready`=0, `busy`=0, `frames_out`=0; a subsequent start behaves as a fresh run.

Source files
------------

// File: rtl/hs_stream_pkg.sv
// -----------------------------------------------------------------------------
// hs_stream_pkg
// Shared definitions for the pad-to-DSP stream sequencer:
//   - default widths for sample data, frame length and frame count
//   - state encoding of the sequencer FSM
// -----------------------------------------------------------------------------
package hs_stream_pkg;

    localparam int DATA_W = 8;   // pad sample width
    localparam int LEN_W  = 12;  // frame-length counter width
    localparam int FRM_W  = 8;   // frame-count width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // pads gated off, waiting for a start pulse
        RUN   = 2'd1,  // admitting pad samples
        DRAIN = 2'd2   // pads gated off, emptying the skid buffer
    } seq_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry register FIFO placed between the pad stream and the DSP input.
// The output side presents the oldest entry straight from its holding
// register, so data/last never change while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, srst               clock, synchronous active-high reset (flushes)
//   in_valid/in_ready       push handshake, in_data payload
//   out_valid/out_ready     pop handshake, out_data payload
//   fill                    number of occupied entries (0..2)
// -----------------------------------------------------------------------------
module axis_skid_buffer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   fill
);

    logic [1:0]   fill_reg;
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [W-1:0] entry_q [2];
    logic         push;
    logic         pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // One holding register per slot; only the slot under the write pointer
    // loads on a push.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= in_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            fill_reg   <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            fill_reg <= fill_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign in_ready  = (fill_reg != 2'd2);
    assign out_valid = (fill_reg != 2'd0);
    assign out_data  = entry_q[rd_ptr_reg];
    assign fill      = fill_reg;

endmodule

// File: rtl/stream_frame_sequencer.sv
// -----------------------------------------------------------------------------
// stream_frame_sequencer
// Admits pad samples into the DSP chain's in_0 stream, grouping them into
// frames of (cfg_len_m1+1) samples and tagging the final sample with m_last.
// A run covers cfg_num_frames frames (0 = continuous until cfg_stop). A stop
// always completes the frame in progress before the pads are gated off.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   cfg_start, cfg_stop     one-cycle control pulses
//   cfg_len_m1              samples per frame minus one (latched on start)
//   cfg_num_frames          frames per run, 0 = continuous (latched on start)
//   s_valid, s_data         pad stream in; s_ready is a registered ready
//   m_valid, m_data, m_last stream out to in_0; m_ready from in_0_ready
//   busy                    FSM not idle
//   done                    one-cycle pulse when a run has fully drained
//   frames_out              frames delivered downstream (saturating)
// -----------------------------------------------------------------------------
module stream_frame_sequencer
    import hs_stream_pkg::*;
#(
    parameter int DATA_W = hs_stream_pkg::DATA_W,
    parameter int LEN_W  = hs_stream_pkg::LEN_W,
    parameter int FRM_W  = hs_stream_pkg::FRM_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [LEN_W-1:0]  cfg_len_m1,
    input  logic [FRM_W-1:0]  cfg_num_frames,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [FRM_W-1:0]  frames_out
);

    seq_state_e        state_reg;
    seq_state_e        state_next;
    logic [LEN_W-1:0]  len_m1_reg;
    logic [FRM_W-1:0]  num_frames_reg;
    logic [LEN_W-1:0]  in_cnt_reg;
    logic [FRM_W-1:0]  frames_in_reg;
    logic [FRM_W-1:0]  frames_out_reg;
    logic              stop_pend_reg;
    logic              s_ready_reg;
    logic              done_reg;

    logic              buf_in_ready;
    logic [DATA_W:0]   buf_out;
    logic [1:0]        fill;
    logic [1:0]        fill_next;
    logic              accept;
    logic              pop;
    logic              in_last;
    logic              frame_done;
    logic              end_run;

    // buf_in_ready is redundant with s_ready_reg (which already reflects the
    // fill level) but keeps a push into a full buffer structurally impossible.
    assign accept     = s_valid & s_ready_reg & buf_in_ready;
    assign pop        = m_valid & m_ready;
    assign in_last    = (in_cnt_reg == len_m1_reg);
    assign frame_done = accept & in_last;
    assign fill_next  = fill + {1'b0, accept} - {1'b0, pop};

    // A frame closing on the input side ends the run if a stop is pending,
    // arrives this very cycle, or the programmed frame count is reached.
    assign end_run = stop_pend_reg | cfg_stop |
                     ((num_frames_reg != '0) &&
                      ((frames_in_reg + FRM_W'(1)) == num_frames_reg));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg_start)              state_next = RUN;
            RUN:     if (frame_done && end_run)  state_next = DRAIN;
            DRAIN:   if (fill == 2'd0)           state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= IDLE;
            len_m1_reg     <= '0;
            num_frames_reg <= '0;
            in_cnt_reg     <= '0;
            frames_in_reg  <= '0;
            frames_out_reg <= '0;
            stop_pend_reg  <= 1'b0;
            s_ready_reg    <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Ready looks one cycle ahead so the pads never see a ready that
            // the buffer cannot honour.
            s_ready_reg <= (state_next == RUN) && (fill_next < 2'd2);
            done_reg    <= (state_reg == DRAIN) && (state_next == IDLE);

            if ((state_reg == IDLE) && cfg_start) begin
                len_m1_reg     <= cfg_len_m1;
                num_frames_reg <= cfg_num_frames;
                in_cnt_reg     <= '0;
                frames_in_reg  <= '0;
                frames_out_reg <= '0;
                stop_pend_reg  <= 1'b0;
            end else begin
                if (accept) begin
                    in_cnt_reg <= in_last ? '0 : in_cnt_reg + LEN_W'(1);
                end
                if (frame_done) begin
                    frames_in_reg <= frames_in_reg + FRM_W'(1);
                end
                if ((state_reg == RUN) && cfg_stop) begin
                    stop_pend_reg <= 1'b1;
                end
                if (pop && buf_out[DATA_W] && (frames_out_reg != '1)) begin
                    frames_out_reg <= frames_out_reg + FRM_W'(1);
                end
            end
        end
    end

    axis_skid_buffer #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .in_valid  (accept),
        .in_ready  (buf_in_ready),
        .in_data   ({in_last, s_data}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (buf_out),
        .fill      (fill)
    );

    assign m_data     = buf_out[DATA_W-1:0];
    assign m_last     = buf_out[DATA_W];
    assign s_ready    = s_ready_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign frames_out = frames_out_reg;

endmodule
